// File: rtl/mul_div_unit_pkg.sv
// Shared mul/div definitions: op encodings, FSM state encoding and op decode helpers.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: takes magnitudes of operands and restores result signs.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
// Handshake: start is accepted only in IDLE without flush; busy stays high until the
// unit is back in IDLE; done pulses for one cycle exactly when hi/lo take the new result.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic             is_div_q;
  logic             neg_q;
  logic             sa_q;
  logic             div0_q;

  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sa_in = op_is_signed(op) & a[WIDTH-1];
  assign sb_in = op_is_signed(op) & b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) u_mag_a (.val(a), .neg(sa_in), .res(mag_a));
  md_sign_fix #(.W(WIDTH)) u_mag_b (.val(b), .neg(sb_in), .res(mag_b));

  // acc:mq is the running product (acc upper) or remainder:quotient pair.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;

  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, mcand};
  assign div_ok    = ~div_trial[WIDTH+1];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val({acc, mq}), .neg(neg_q), .res(prod_fix));
  // Divide by zero leaves the all-ones quotient raw; the remainder sign fix turns |a| back into a.
  md_sign_fix #(.W(WIDTH)) u_fix_quot (.val(mq), .neg(neg_q & ~div0_q), .res(quot_fix));
  md_sign_fix #(.W(WIDTH)) u_fix_rem (.val(acc), .neg(sa_q), .res(rem_fix));

  assign res_hi = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div0_q   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            acc      <= '0;
            mq       <= mag_a;
            mcand    <= mag_b;
            cnt      <= CNT_W'(WIDTH);
            is_div_q <= op_is_div(op);
            neg_q    <= sa_in ^ sb_in;
            sa_q     <= sa_in;
            div0_q   <= op_is_div(op) && (b == '0);
            state    <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (is_div_q) begin
              acc <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], div_ok};
            end else begin
              acc <= mul_sum[WIDTH:1];
              mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: driver tasks push expected HI/LO into a queue,
// a monitor pops and compares on every done pulse, including start-to-done latency.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int vecs      = 0;
  int errs      = 0;
  int cyc       = 0;
  int start_cyc = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_e;

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op        = o;
    a         = x;
    b         = y;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_result(input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_q.push_back({eh, el});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", W'(busy), '0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    expect_result(eh, el);
    issue(o, x, y);
    wait_idle(LAT + 10);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          check("hi", hi, exp_e[2*W-1:W]);
          check("lo", lo, exp_e[W-1:0]);
          check("latency", W'(cyc - start_cyc), W'(LAT));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    tick();
    tick();
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_state", W'(dbg_state), '0);
    rst = 1'b0;
    tick();

    // arithmetic vectors: op 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);

    // DIV -7/2 with an ignored second start mid-operation
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(2'd2, 32'hFFFFFFF9, 32'h00000002);
    repeat (5) tick();
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(LAT + 10);

    run_op(2'd3, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op(2'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(2'd0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB);

    // MTHI / MTLO in idle
    hi_we = 1'b1; wdata = 32'h00001234;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00005678;
    tick();
    lo_we = 1'b0;
    check("mthi", hi, 32'h00001234);
    check("mtlo", lo, 32'h00005678);

    // flush mid-MULT, then restart on the following cycle
    issue(2'd0, 32'd3, 32'd4);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    check("flush_hi", hi, 32'h00001234);
    check("flush_lo", lo, 32'h00005678);
    run_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    // flush wins over start in idle
    flush = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_start_busy", W'(busy), '0);
    repeat (3) tick();

    // write alongside an accepted start lands now, result overwrites later
    expect_result(32'd1, 32'd4);
    hi_we = 1'b1; wdata = 32'h0000AAAA;
    issue(2'd3, 32'd9, 32'd2);
    hi_we = 1'b0;
    check("we_with_start", hi, 32'h0000AAAA);
    wait_idle(LAT + 10);

    // lo_we while busy is ignored
    expect_result(32'd0, 32'd6);
    issue(2'd1, 32'd2, 32'd3);
    repeat (3) tick();
    lo_we = 1'b1; wdata = 32'h0000DEAD;
    tick();
    lo_we = 1'b0;
    check("lo_we_busy", lo, 32'd4);
    check("calc_state", W'(dbg_state), W'(1));
    wait_idle(LAT + 10);

    // reset mid-DIV: everything cleared, no done afterwards
    issue(2'd2, 32'd100, 32'hFFFFFFFD);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_hi", hi, '0);
    check("rst_mid_lo", lo, '0);
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_done", W'(done), '0);
    repeat (40) tick();

    run_op(2'd0, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF6);
    repeat (3) tick();

    check("pending_results", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
